spi_byte_seq: RTL and testbench

- Host-side sequencer that sits directly upstream of the SPI master byte engine.
- Buffers host TX bytes in a FIFO and issues one-byte transfers to the master via a start pulse.
- Collects each received byte into an RX FIFO for the host.
- Watchdog flags a master that never completes a byte; issuing stops until software clears the flag.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_sync_fifo.sv | 73 +++++++
 rtl/spi_byte_seq.sv | 148 ++++++++++++++
 tb/tb_spi_byte_seq.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and default sizing for the SPI byte sequencer slice.
package spi_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } seq_state_t;

  localparam int DEFAULT_DEPTH   = 8;
  localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/spi_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with valid/ready on both sides
// and an occupancy output. FULL_POP_PUSH lets a push land in the slot that a
// same-cycle pop frees when the FIFO is full.
module spi_sync_fifo
  import spi_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = DEFAULT_DEPTH,
  parameter bit FULL_POP_PUSH = 1'b0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_wr_valid,
  output logic                     o_wr_ready,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_rd_valid,
  input  logic                     i_rd_ready,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full     = (r_count == FULL_LEVEL);
  assign w_empty    = (r_count == {LW{1'b0}});
  assign o_wr_ready = !w_full || (FULL_POP_PUSH && i_rd_ready);
  assign o_rd_valid = !w_empty;
  assign o_rd_data  = r_mem[r_rd_ptr];
  assign o_level    = r_count;
  assign w_push     = i_wr_valid && o_wr_ready;
  assign w_pop      = !w_empty && i_rd_ready;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {LW{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents need no reset because occupancy gates reads.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

endmodule

// File: rtl/spi_byte_seq.sv
// Host-side sequencer feeding an SPI master one byte at a time: TX bytes are
// buffered, issued with a start pulse, and each received byte is collected
// into an RX FIFO. A watchdog latches an error if the master never finishes.
module spi_byte_seq
  import spi_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [7:0]             i_tx_data,
  input  logic                   i_tx_valid,
  output logic                   o_tx_ready,
  output logic [7:0]             o_rx_data,
  output logic                   o_rx_valid,
  input  logic                   i_rx_ready,
  output logic [7:0]             o_spi_tx_byte,
  output logic                   o_spi_tx_start,
  input  logic                   i_spi_done,
  input  logic [7:0]             i_spi_rx_byte,
  output logic                   o_busy,
  output logic [$clog2(DEPTH):0] o_tx_level,
  output logic                   o_err_timeout,
  input  logic                   i_err_clr
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST    = TW'(TIMEOUT - 1);
  localparam logic [LW-1:0] RX_FULL_LEVEL = LW'(DEPTH);

  seq_state_t    r_state;
  logic [TW-1:0] r_timer;
  byte_t         r_spi_tx_byte;
  logic          r_spi_tx_start;
  logic          r_err_timeout;

  byte_t         w_tx_head;
  logic          w_tx_head_valid;
  logic [LW-1:0] w_tx_level;
  logic [LW-1:0] w_rx_level;
  logic          w_rx_wr_ready;
  logic          w_issue;
  logic          w_rx_push;
  logic          w_timeout;

  spi_sync_fifo #(
    .WIDTH        (8),
    .DEPTH        (DEPTH),
    .FULL_POP_PUSH(1'b0)
  ) u_tx_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_data (i_tx_data),
    .i_wr_valid(i_tx_valid),
    .o_wr_ready(o_tx_ready),
    .o_rd_data (w_tx_head),
    .o_rd_valid(w_tx_head_valid),
    .i_rd_ready(w_issue),
    .o_level   (w_tx_level)
  );

  spi_sync_fifo #(
    .WIDTH        (8),
    .DEPTH        (DEPTH),
    .FULL_POP_PUSH(1'b1)
  ) u_rx_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_data (i_spi_rx_byte),
    .i_wr_valid(w_rx_push),
    .o_wr_ready(w_rx_wr_ready),
    .o_rd_data (o_rx_data),
    .o_rd_valid(o_rx_valid),
    .i_rd_ready(i_rx_ready),
    .o_level   (w_rx_level)
  );

  // Decode issue / completion / watchdog events for the current state.
  // RX space is reserved at issue time so the reply always has a slot.
  always_comb begin
    w_issue   = 1'b0;
    w_rx_push = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        w_issue = w_tx_head_valid && (w_rx_level < RX_FULL_LEVEL) && !r_err_timeout;
      end
      WAIT: begin
        w_rx_push = i_spi_done && w_rx_wr_ready;
        w_timeout = !i_spi_done && (r_timer == TIMER_LAST);
      end
      default: begin
        w_issue   = 1'b0;
        w_rx_push = 1'b0;
        w_timeout = 1'b0;
      end
    endcase
  end

  // Sequencer FSM, watchdog timer and sticky error (a set beats a clear).
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state        <= IDLE;
      r_timer        <= {TW{1'b0}};
      r_spi_tx_byte  <= 8'h00;
      r_spi_tx_start <= 1'b0;
      r_err_timeout  <= 1'b0;
    end else begin
      r_spi_tx_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_spi_tx_byte  <= w_tx_head;
            r_spi_tx_start <= 1'b1;
            r_timer        <= {TW{1'b0}};
            r_state        <= WAIT;
          end
        end
        WAIT: begin
          if (i_spi_done || w_timeout) begin
            r_timer <= {TW{1'b0}};
            r_state <= IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: begin
          r_timer <= {TW{1'b0}};
          r_state <= IDLE;
        end
      endcase
      if (w_timeout) begin
        r_err_timeout <= 1'b1;
      end else if (i_err_clr) begin
        r_err_timeout <= 1'b0;
      end
    end
  end

  assign o_spi_tx_byte  = r_spi_tx_byte;
  assign o_spi_tx_start = r_spi_tx_start;
  assign o_err_timeout  = r_err_timeout;
  assign o_tx_level     = w_tx_level;
  assign o_busy         = (r_state != IDLE) || w_tx_head_valid;

endmodule

// File: tb/tb_spi_byte_seq.sv
// Scoreboard bench for spi_byte_seq: expected start bytes and RX bytes are
// queued as stimulus is issued and popped by an independent monitor.
module tb_spi_byte_seq;
  import spi_pkg::*;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 64;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [7:0] i_tx_data;
  logic       i_tx_valid;
  logic       o_tx_ready;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       i_rx_ready;
  logic [7:0] o_spi_tx_byte;
  logic       o_spi_tx_start;
  logic       i_spi_done;
  logic [7:0] i_spi_rx_byte;
  logic       o_busy;
  logic [3:0] o_tx_level;
  logic       o_err_timeout;
  logic       i_err_clr;

  always #5 i_clk = ~i_clk;

  spi_byte_seq #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_tx_data     (i_tx_data),
    .i_tx_valid    (i_tx_valid),
    .o_tx_ready    (o_tx_ready),
    .o_rx_data     (o_rx_data),
    .o_rx_valid    (o_rx_valid),
    .i_rx_ready    (i_rx_ready),
    .o_spi_tx_byte (o_spi_tx_byte),
    .o_spi_tx_start(o_spi_tx_start),
    .i_spi_done    (i_spi_done),
    .i_spi_rx_byte (i_spi_rx_byte),
    .o_busy        (o_busy),
    .o_tx_level    (o_tx_level),
    .o_err_timeout (o_err_timeout),
    .i_err_clr     (i_err_clr)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_start  = 0;
  int    n_rx     = 0;
  byte_t exp_start[$];
  byte_t exp_rx[$];

  // Master model controls
  int    m_delay      = 16;
  bit    m_never      = 1'b0;
  bit    m_rand_delay = 1'b0;
  bit    m_fixed_rx   = 1'b0;
  byte_t m_rx_val     = 8'h00;
  int    m_inject_req = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_byte(input byte_t b, output int waits);
    waits      = 0;
    i_tx_valid = 1'b1;
    i_tx_data  = b;
    while (!o_tx_ready && waits < 3000) begin
      tick();
      waits++;
    end
    if (o_tx_ready) begin
      exp_start.push_back(b);
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: got ready=0 expected ready=1 for byte 0x%02h", b);
    end
    tick();
    i_tx_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int i;
    i = 0;
    i_rx_ready = 1'b1;
    while ((exp_start.size() != 0 || exp_rx.size() != 0 || o_busy || o_rx_valid) && i < 5000) begin
      tick();
      i++;
    end
    chk(name, exp_start.size() + exp_rx.size() + int'(o_busy) + int'(o_rx_valid), 0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_start"}, o_spi_tx_start, 0);
    chk({tag, "_byte"},  o_spi_tx_byte,  0);
    chk({tag, "_err"},   o_err_timeout,  0);
    chk({tag, "_rxv"},   o_rx_valid,     0);
    chk({tag, "_txrdy"}, o_tx_ready,     1);
    chk({tag, "_busy"},  o_busy,         0);
    chk({tag, "_level"}, o_tx_level,     0);
  endtask

  // Behavioural SPI master: answers each start after a chosen delay.
  initial begin : master
    int    cnt;
    int    dly;
    int    inj_ack;
    bit    pend;
    byte_t b;
    i_spi_done    = 1'b0;
    i_spi_rx_byte = 8'h00;
    cnt = 0; dly = 0; inj_ack = 0; pend = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      i_spi_done = 1'b0;
      if (o_spi_tx_start && !m_never && !pend) begin
        pend = 1'b1;
        cnt  = 0;
        dly  = m_rand_delay ? int'($urandom_range(0, TIMEOUT - 2)) : m_delay;
      end else if (pend) begin
        cnt++;
      end
      if (pend && cnt == dly) begin
        b = m_fixed_rx ? m_rx_val : byte_t'($urandom_range(0, 255));
        i_spi_done    = 1'b1;
        i_spi_rx_byte = b;
        pend          = 1'b0;
        if (dly <= TIMEOUT - 1) exp_rx.push_back(b);
      end else if (m_inject_req != inj_ack) begin
        inj_ack       = m_inject_req;
        i_spi_done    = 1'b1;
        i_spi_rx_byte = 8'hEE;
      end
    end
  end

  // Monitor: compares every start pulse and every RX pop against the queues.
  initial begin : monitor
    byte_t e;
    forever begin
      @(negedge i_clk);
      if (i_rst_n) begin
        if (o_spi_tx_start) begin
          n_start++;
          if (exp_start.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL start_unexpected: got byte 0x%02h expected no start", o_spi_tx_byte);
          end else begin
            e = exp_start.pop_front();
            chk("start_byte", o_spi_tx_byte, e);
          end
        end
        if (o_rx_valid && i_rx_ready) begin
          n_rx++;
          if (exp_rx.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_unexpected: got byte 0x%02h expected no rx", o_rx_data);
          end else begin
            e = exp_rx.pop_front();
            chk("rx_byte", o_rx_data, e);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int s0;
    int w;
    int stalls;
    int acc;
    int i;
    i_rst_n    = 1'b0;
    i_tx_valid = 1'b0;
    i_tx_data  = 8'h00;
    i_rx_ready = 1'b1;
    i_err_clr  = 1'b0;
    repeat (3) tick();
    i_rst_n = 1'b1;
    chk_reset_values("rst");
    tick();

    // Single byte with latency checks
    m_delay = 16; m_fixed_rx = 1'b1; m_rx_val = 8'h3C; i_rx_ready = 1'b0;
    s0 = n_start;
    i_tx_valid = 1'b1; i_tx_data = 8'hA5;
    chk("t1_ready", o_tx_ready, 1);
    exp_start.push_back(8'hA5);
    tick();
    i_tx_valid = 1'b0;
    chk("t1_nostart_k", o_spi_tx_start, 0);
    chk("t1_level_k", o_tx_level, 1);
    tick();
    chk("t1_start_k1", o_spi_tx_start, 1);
    chk("t1_byte", o_spi_tx_byte, 8'hA5);
    i = 0;
    while (!o_rx_valid && i < 200) begin tick(); i++; end
    chk("t1_rx_valid", o_rx_valid, 1);
    chk("t1_rx_data", o_rx_data, 8'h3C);
    chk("t1_byte_hold", o_spi_tx_byte, 8'hA5);
    i_rx_ready = 1'b1;
    tick();
    chk("t1_rx_empty", o_rx_valid, 0);
    chk("t1_busy", o_busy, 0);
    chk("t1_nstart", n_start - s0, 1);
    m_fixed_rx = 1'b0;

    // Burst into a stalled master: 9 accepted, then full
    m_delay = 30; s0 = n_start; stalls = 0;
    for (int b = 1; b <= 9; b++) begin
      push_byte(byte_t'(b), w);
      stalls += w;
    end
    chk("t2_no_stall", stalls, 0);
    chk("t2_ready_low", o_tx_ready, 0);
    chk("t2_level_full", o_tx_level, DEPTH);
    drain("t2_drain");
    chk("t2_nstart", n_start - s0, 9);

    // RX backpressure: space reservation limits starts to DEPTH
    m_delay = 3; i_rx_ready = 1'b0; s0 = n_start;
    for (int b = 0; b < 10; b++) push_byte(byte_t'(8'h40 + b), w);
    repeat (150) tick();
    chk("t3_starts_full", n_start - s0, DEPTH);
    chk("t3_tx_level", o_tx_level, 2);
    chk("t3_rx_valid", o_rx_valid, 1);
    i_rx_ready = 1'b1;
    tick();
    i_rx_ready = 1'b0;
    repeat (40) tick();
    chk("t3_starts_after_pop", n_start - s0, DEPTH + 1);
    chk("t3_tx_level2", o_tx_level, 1);
    drain("t3_drain");
    chk("t3_nstart", n_start - s0, 10);

    // Timeout, set-beats-clear, and blocked issue until cleared
    m_never = 1'b1; s0 = n_start;
    push_byte(8'h55, w);
    i = 0;
    while (!o_spi_tx_start && i < 20) begin tick(); i++; end
    chk("t4_start55", o_spi_tx_start, 1);
    push_byte(8'h66, w);
    repeat (TIMEOUT - 2) tick();
    chk("t4_err_before", o_err_timeout, 0);
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    chk("t4_err_set", o_err_timeout, 1);
    chk("t4_no_rx", o_rx_valid, 0);
    repeat (20) tick();
    chk("t4_blocked", n_start - s0, 1);
    chk("t4_level", o_tx_level, 1);
    chk("t4_err_sticky", o_err_timeout, 1);
    m_never = 1'b0; m_delay = 5;
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    chk("t4_err_clr", o_err_timeout, 0);
    tick();
    chk("t4_start66", o_spi_tx_start, 1);
    chk("t4_byte66", o_spi_tx_byte, 8'h66);
    drain("t4_drain");
    chk("t4_nstart", n_start - s0, 2);

    // Done on the last watchdog cycle wins
    m_delay = TIMEOUT - 1; s0 = n_rx;
    push_byte(8'h77, w);
    drain("t5_drain");
    chk("t5_err", o_err_timeout, 0);
    chk("t5_nrx", n_rx - s0, 1);

    // Randomised traffic
    m_rand_delay = 1'b1; s0 = n_start; acc = 0;
    for (int c = 0; c < 400; c++) begin
      i_tx_valid = ($urandom_range(0, 2) == 0);
      i_tx_data  = byte_t'($urandom_range(0, 255));
      i_rx_ready = ($urandom_range(0, 3) != 0);
      if (i_tx_valid && o_tx_ready) begin
        exp_start.push_back(i_tx_data);
        acc++;
      end
      tick();
    end
    i_tx_valid = 1'b0;
    drain("t6_drain");
    chk("t6_nstart", n_start - s0, acc);
    chk("t6_err", o_err_timeout, 0);
    m_rand_delay = 1'b0;

    // Reset mid-WAIT with queued bytes, then a late done
    m_never = 1'b1;
    for (int b = 0; b < 4; b++) push_byte(byte_t'(8'hA1 + b), w);
    repeat (5) tick();
    chk("t7_busy", o_busy, 1);
    chk("t7_level", o_tx_level, 3);
    i_rst_n = 1'b0;
    tick();
    exp_start.delete();
    i_rst_n = 1'b1;
    chk_reset_values("t7");
    s0 = n_start;
    m_inject_req++;
    repeat (6) tick();
    chk("t7_late_rxv", o_rx_valid, 0);
    chk("t7_late_busy", o_busy, 0);
    chk("t7_late_start", n_start - s0, 0);
    chk("t7_late_level", o_tx_level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
